// File: rtl/cspi_pkg.sv
// Shared definitions for the control-SPI master: FSM encoding, idle line level
// and default timing parameters.
package cspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LO    = 3'd2,
    ST_HI    = 3'd3,
    ST_END   = 3'd4,
    ST_NEXT  = 3'd5,
    ST_HOLD  = 3'd6,
    ST_GAP   = 3'd7
  } cspi_st_e;

  localparam logic CSPI_MOSI_IDLE = 1'b1;
  localparam int   CSPI_HALF_DEF  = 50;
  localparam int   CSPI_GAP_DEF   = 100;
  localparam int   CSPI_CNT_W     = 16;

endpackage

// File: rtl/cspi_halfcnt.sv
// Loadable down-counter; tc is high on the last cycle of a loaded interval,
// so loading N-1 on state entry gives a state that lasts exactly N cycles.
module cspi_halfcnt #(
  parameter int W = 16
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/cspi_mst.sv
// Control-SPI master: bytes in on a valid/ready port, shifted out MSB first,
// miso byte returned per transfer. All cspi_* outputs are registered.
module cspi_mst
  import cspi_pkg::*;
#(
  parameter int HALF   = CSPI_HALF_DEF,
  parameter int CS_GAP = CSPI_GAP_DEF
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  input  logic       tx_last,
  output logic       tx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       busy,
  output logic       cspi_csn,
  output logic       cspi_sck,
  output logic       cspi_mosi,
  input  logic       cspi_miso
);

  localparam logic [CSPI_CNT_W-1:0] HALF_LD = CSPI_CNT_W'(HALF - 1);
  localparam logic [CSPI_CNT_W-1:0] GAP_LD  = CSPI_CNT_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);
  localparam bit                    HAS_GAP = (CS_GAP > 0);

  cspi_st_e   st, st_nxt;
  logic [2:0] bcnt;
  logic [7:0] shift_tx, shift_tx_nxt, shift_rx;
  logic       last_f, miso_m, miso_s;
  logic       half_tc, gap_tc, half_ld, gap_ld, accept, bit_done;

  assign accept   = tx_vld & tx_rdy;
  assign bit_done = (st == ST_HI) && half_tc;
  assign half_ld  = (st_nxt != st);
  assign gap_ld   = (st_nxt == ST_GAP) && (st != ST_GAP);

  cspi_halfcnt #(.W(CSPI_CNT_W)) u_half (
    .clk_sys (clk_sys),
    .rst     (rst),
    .load    (half_ld),
    .val     (HALF_LD),
    .tc      (half_tc)
  );

  cspi_halfcnt #(.W(CSPI_CNT_W)) u_gap (
    .clk_sys (clk_sys),
    .rst     (rst),
    .load    (gap_ld),
    .val     (GAP_LD),
    .tc      (gap_tc)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  if (accept)  st_nxt = ST_SETUP;
      ST_SETUP: if (half_tc) st_nxt = ST_HI;
      ST_LO:    if (half_tc) st_nxt = ST_HI;
      ST_HI:    if (half_tc) st_nxt = (bcnt == 3'd7) ? ST_END : ST_LO;
      ST_END:   st_nxt = last_f ? ST_HOLD : ST_NEXT;
      ST_NEXT:  if (accept)  st_nxt = ST_LO;
      // with no gap configured, csn goes straight back to IDLE
      ST_HOLD:  if (half_tc) st_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_tc)  st_nxt = ST_IDLE;
      default:  st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_tx_nxt = shift_tx;
    if (accept)        shift_tx_nxt = tx_data;
    else if (bit_done) shift_tx_nxt = {shift_tx[6:0], 1'b0};
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      bcnt      <= '0;
      shift_tx  <= '0;
      shift_rx  <= '0;
      last_f    <= 1'b0;
      miso_m    <= 1'b0;
      miso_s    <= 1'b0;
      tx_rdy    <= 1'b0;
      rx_data   <= 8'hFF;
      rx_vld    <= 1'b0;
      busy      <= 1'b0;
      cspi_csn  <= 1'b1;
      cspi_sck  <= 1'b0;
      cspi_mosi <= CSPI_MOSI_IDLE;
    end else begin
      miso_m   <= cspi_miso;
      miso_s   <= miso_m;
      shift_tx <= shift_tx_nxt;
      if (accept) last_f <= tx_last;
      if (bit_done) begin
        shift_rx <= {shift_rx[6:0], miso_s};
        if (bcnt != 3'd7) bcnt <= bcnt + 3'd1;
      end
      if (st == ST_END) begin
        bcnt    <= '0;
        rx_data <= shift_rx;
      end
      rx_vld <= (st == ST_END);
      // mosi is only reloaded when a bit is about to be presented; after the
      // 8th bit it holds until the next byte or the idle level takes over
      case (st_nxt)
        ST_IDLE, ST_GAP: cspi_mosi <= CSPI_MOSI_IDLE;
        ST_SETUP, ST_LO: cspi_mosi <= shift_tx_nxt[7];
        default: ;
      endcase
      cspi_csn <= (st_nxt == ST_IDLE) || (st_nxt == ST_GAP);
      cspi_sck <= (st_nxt == ST_HI);
      tx_rdy   <= (st_nxt == ST_IDLE) || (st_nxt == ST_NEXT);
      busy     <= (st_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_cspi_mst.sv
// Directed bench for cspi_mst: one instance at HALF=4/CS_GAP=10 for framing,
// data and reset cases, one at HALF=8/CS_GAP=0 for back-to-back frames.
module tb_cspi_mst;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       rst, tx_vld, tx_last, tx_rdy, rx_vld, busy, csn, sck, mosi, miso;
  logic [7:0] tx_data, rx_data;
  int         miso_mode;
  logic [23:0] slv_resp, slv_sr;
  logic        slv_csn_d, slv_sck_d;

  logic       b_rst, b_tx_vld, b_tx_last, b_tx_rdy, b_rx_vld, b_busy, b_csn, b_sck, b_mosi;
  logic [7:0] b_tx_data, b_rx_data;

  int checks = 0, fails = 0;

  cspi_mst #(.HALF(4), .CS_GAP(10)) u_a (
    .clk_sys(clk_sys), .rst(rst), .tx_data(tx_data), .tx_vld(tx_vld), .tx_last(tx_last),
    .tx_rdy(tx_rdy), .rx_data(rx_data), .rx_vld(rx_vld), .busy(busy),
    .cspi_csn(csn), .cspi_sck(sck), .cspi_mosi(mosi), .cspi_miso(miso)
  );

  cspi_mst #(.HALF(8), .CS_GAP(0)) u_b (
    .clk_sys(clk_sys), .rst(b_rst), .tx_data(b_tx_data), .tx_vld(b_tx_vld), .tx_last(b_tx_last),
    .tx_rdy(b_tx_rdy), .rx_data(b_rx_data), .rx_vld(b_rx_vld), .busy(b_busy),
    .cspi_csn(b_csn), .cspi_sck(b_sck), .cspi_mosi(b_mosi), .cspi_miso(b_mosi)
  );

  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b0 : slv_sr[23];

  // behavioural slave: loads response on csn fall, shifts on each sck fall
  always @(posedge clk_sys) begin
    if (slv_csn_d === 1'b1 && csn === 1'b0) slv_sr <= slv_resp;
    else if (slv_sck_d === 1'b1 && sck === 1'b0) slv_sr <= {slv_sr[22:0], 1'b0};
    slv_csn_d <= csn;
    slv_sck_d <= sck;
  end

  int          m_rises = 0, rx_cnt = 0, csn_rises = 0, rdy_bad = 0;
  logic [31:0] m_bits = '0;
  logic [7:0]  rx_log [16];
  logic        m_sck_d = 1'b0, m_csn_d = 1'b0;

  always @(negedge clk_sys) begin
    if (sck === 1'b1 && m_sck_d === 1'b0) begin
      m_rises++;
      m_bits = {m_bits[30:0], mosi};
    end
    if (rx_vld === 1'b1) begin
      rx_log[rx_cnt % 16] = rx_data;
      rx_cnt++;
    end
    if (csn === 1'b1 && m_csn_d === 1'b0) csn_rises++;
    if (tx_rdy === 1'b1 && (sck === 1'b1 || (csn === 1'b1 && busy === 1'b1))) rdy_bad++;
    m_sck_d = sck;
    m_csn_d = csn;
  end

  int b_hi = 0, b_gaps = 0, b_gap_min = 1000, b_gap_max = 0;
  int b_vrun = 0, b_vmax = 0, b_rxn = 0, b_rx_bad = 0;
  logic b_seen_lo = 1'b0;

  always @(negedge clk_sys) begin
    if (b_csn === 1'b1) b_hi++;
    else if (b_csn === 1'b0) begin
      if (b_seen_lo && b_hi > 0) begin
        b_gaps++;
        if (b_hi > b_gap_max) b_gap_max = b_hi;
        if (b_hi < b_gap_min) b_gap_min = b_hi;
      end
      b_hi = 0;
      b_seen_lo = 1'b1;
    end
    if (b_rx_vld === 1'b1) begin
      b_vrun++;
      if (b_vrun == 1) b_rxn++;
      if (b_vrun > b_vmax) b_vmax = b_vrun;
      if (b_rx_data !== 8'h96) b_rx_bad++;
    end else b_vrun = 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    tx_data = d; tx_last = l; tx_vld = 1'b1; n = 0;
    while (tx_rdy !== 1'b1 && n < 3000) begin @(negedge clk_sys); n++; end
    chk("send_timeout", 32'(n < 3000), 1);
    @(negedge clk_sys);
    tx_vld = 1'b0; tx_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk_sys); n++; end
    chk({tag, "_idle_timeout"}, 32'(n < 3000), 1);
  endtask

  initial begin
    int n, p, r0, x0, c0, b0, nacc;
    logic [7:0] expb [3];
    logic prev;
    rst = 1'b1; tx_vld = 1'b0; tx_data = '0; tx_last = 1'b0; miso_mode = 0; slv_resp = '0;
    b_rst = 1'b1; b_tx_vld = 1'b0; b_tx_data = '0; b_tx_last = 1'b0;
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;
    chk("rst_csn", csn, 1);     chk("rst_sck", sck, 0);     chk("rst_mosi", mosi, 1);
    chk("rst_rdy", tx_rdy, 0);  chk("rst_rxvld", rx_vld, 0); chk("rst_rxdata", rx_data, 8'hFF);
    chk("rst_busy", busy, 0);
    @(negedge clk_sys);
    chk("idle_rdy", tx_rdy, 1);

    // single byte, loopback
    r0 = m_rises; x0 = rx_cnt;
    send(8'hA5, 1'b1);
    chk("t1_csn_fall", csn, 0);
    n = 0;
    while (sck !== 1'b1 && n < 100) begin @(negedge clk_sys); n++; end
    chk("t1_first_rise", n, 4);
    p = 0;
    while (sck === 1'b1 && p < 100) begin @(negedge clk_sys); p++; end
    while (sck !== 1'b1 && p < 100) begin @(negedge clk_sys); p++; end
    chk("t1_period", p, 8);
    n = 0;
    while (rx_vld !== 1'b1 && n < 500) begin @(negedge clk_sys); n++; end
    chk("t1_rx_timeout", 32'(n < 500), 1);
    chk("t1_rx_data", rx_data, 8'hA5);
    n = 0;
    while (csn !== 1'b1 && n < 100) begin n++; @(negedge clk_sys); end
    chk("t1_hold_len", n, 4);
    n = 0;
    while (tx_rdy !== 1'b1 && n < 100) begin n++; @(negedge clk_sys); end
    chk("t1_gap_len", n, 10);
    chk("t1_busy_idle", busy, 0);
    chk("t1_mosi_idle", mosi, 1);
    chk("t1_rises", m_rises - r0, 8);
    chk("t1_mosi_bits", m_bits[7:0], 8'hA5);
    chk("t1_rx_pulses", rx_cnt - x0, 1);

    // three-byte frame, miso low
    miso_mode = 1; r0 = m_rises; x0 = rx_cnt; c0 = csn_rises; b0 = rdy_bad;
    send(8'h01, 1'b0); send(8'h80, 1'b0); send(8'hFF, 1'b1);
    wait_idle("t2");
    chk("t2_rises", m_rises - r0, 24);
    chk("t2_csn_rises", csn_rises - c0, 1);
    chk("t2_rx_pulses", rx_cnt - x0, 3);
    chk("t2_rx_or", {24'h0, rx_log[x0 % 16] | rx_log[(x0 + 1) % 16] | rx_log[(x0 + 2) % 16]}, 0);
    chk("t2_mosi_bits", m_bits[23:0], 24'h0180FF);
    chk("t2_rdy_state", rdy_bad - b0, 0);

    // behavioural slave responses
    miso_mode = 2; slv_resp = 24'h113CC3; x0 = rx_cnt;
    send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b1);
    wait_idle("t3");
    chk("t3_rx0", rx_log[x0 % 16], 8'h11);
    chk("t3_rx1", rx_log[(x0 + 1) % 16], 8'h3C);
    chk("t3_rx2", rx_log[(x0 + 2) % 16], 8'hC3);
    chk("t3_mosi_bits", m_bits[23:0], 24'h123456);

    // tx_vld held with data changing every cycle
    miso_mode = 0; r0 = m_rises; x0 = rx_cnt; nacc = 0; n = 0; tx_vld = 1'b1;
    while (nacc < 3 && n < 3000) begin
      tx_data = 8'h40 + n[7:0];
      tx_last = (nacc == 2);
      if (tx_rdy === 1'b1) begin expb[nacc] = tx_data; nacc++; end
      @(negedge clk_sys); n++;
    end
    tx_vld = 1'b0; tx_last = 1'b0;
    chk("t4_accepts", nacc, 3);
    chk("t4_first", expb[0], 8'h40);
    wait_idle("t4");
    chk("t4_rises", m_rises - r0, 24);
    chk("t4_mosi_bits", m_bits[23:0], {expb[0], expb[1], expb[2]});
    chk("t4_rx2", rx_log[(x0 + 2) % 16], expb[2]);

    // reset during the 5th HI phase
    x0 = rx_cnt;
    send(8'hC3, 1'b1);
    n = 0; p = 0; prev = sck;
    while (p < 5 && n < 500) begin
      @(negedge clk_sys); n++;
      if (sck === 1'b1 && prev !== 1'b1) p++;
      prev = sck;
    end
    chk("t5_reach_hi5", p, 5);
    @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    rst = 1'b0;
    chk("t5_csn", csn, 1); chk("t5_sck", sck, 0); chk("t5_mosi", mosi, 1);
    chk("t5_rxvld", rx_vld, 0); chk("t5_busy", busy, 0);
    repeat (40) @(negedge clk_sys);
    chk("t5_no_rx", rx_cnt - x0, 0);
    r0 = m_rises;
    send(8'h5A, 1'b1);
    wait_idle("t5");
    chk("t5_rx_data", rx_log[x0 % 16], 8'h5A);
    chk("t5_mosi_bits", m_bits[7:0], 8'h5A);
    chk("t5_rises", m_rises - r0, 8);

    // HALF=8, CS_GAP=0: back-to-back single-byte frames
    b_tx_data = 8'h96; b_tx_last = 1'b1; b_tx_vld = 1'b1;
    b_rst = 1'b0;
    repeat (500) @(negedge clk_sys);
    b_tx_vld = 1'b0;
    repeat (200) @(negedge clk_sys);
    chk("t6_gaps_seen", 32'(b_gaps >= 3), 1);
    chk("t6_gap_max", b_gap_max, 1);
    chk("t6_gap_min", b_gap_min, 1);
    chk("t6_rxvld_width", b_vmax, 1);
    chk("t6_rx_count", 32'(b_rxn >= 3), 1);
    chk("t6_rx_data", b_rx_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
